// File: rtl/video_start_sequencer.sv
// Start-up / mode-change / re-lock sequencer for the RAM-to-video generator.
// Holds the generator stopped until the capture side has a head start.
module video_start_sequencer #(
  parameter int START_LINES     = 2,
  parameter int HOLD_CYCLES     = 4,
  parameter int TRIGGER_TIMEOUT = 1024,
  parameter int FRAME_TIMEOUT   = 4194304
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       line_doubler_req,
  input  logic       add_line_req,
  input  logic       frame_start,
  input  logic       line_done,
  input  logic       restart,
  output logic       out_run,
  output logic       starttrigger,
  output logic       line_doubler,
  output logic       add_line,
  output logic       locked,
  output logic       trig_error,
  output logic [7:0] relock_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_FILL,
    S_TRIG,
    S_RUN,
    S_APPLY
  } state_t;

  localparam logic [7:0]  LP_LINES = 8'(START_LINES);
  localparam logic [7:0]  LP_HOLD  = 8'(HOLD_CYCLES - 1);
  localparam logic [15:0] LP_TRIG  = 16'(TRIGGER_TIMEOUT - 1);
  localparam logic [23:0] LP_WD    = 24'(FRAME_TIMEOUT - 1);

  state_t      r_state;
  logic [7:0]  r_lines;
  logic [7:0]  r_hold;
  logic [15:0] r_tcnt;
  logic [23:0] r_wd;

  logic       w_chg;
  logic [7:0] w_lines_inc;
  logic [7:0] w_relock_inc;

  assign w_chg = {line_doubler_req, add_line_req}
              != {line_doubler, add_line};
  assign w_lines_inc  = r_lines + 8'd1;
  assign w_relock_inc = (relock_count == 8'hFF)
                      ? relock_count
                      : relock_count + 8'd1;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_lines      <= '0;
      r_hold       <= '0;
      r_tcnt       <= '0;
      r_wd         <= '0;
      out_run      <= 1'b0;
      starttrigger <= 1'b0;
      line_doubler <= 1'b0;
      add_line     <= 1'b0;
      locked       <= 1'b0;
      trig_error   <= 1'b0;
      relock_count <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          out_run      <= 1'b0;
          starttrigger <= 1'b0;
          locked       <= 1'b0;
          line_doubler <= line_doubler_req;
          add_line     <= add_line_req;
          r_state      <= S_WAIT;
        end
        S_APPLY: begin
          if (r_hold == LP_HOLD) begin
            line_doubler <= line_doubler_req;
            add_line     <= add_line_req;
            r_state      <= S_WAIT;
          end else begin
            r_hold <= r_hold + 8'd1;
          end
        end
        default: begin
          // config change outranks every other event in active states
          if (w_chg) begin
            r_state      <= S_APPLY;
            r_hold       <= '0;
            out_run      <= 1'b0;
            starttrigger <= 1'b0;
            locked       <= 1'b0;
            relock_count <= w_relock_inc;
          end else begin
            unique case (r_state)
              S_WAIT: begin
                if (frame_start) begin
                  r_lines <= '0;
                  r_state <= S_FILL;
                end
              end
              S_FILL: begin
                if (frame_start) begin
                  r_lines <= '0;
                end else if (line_done) begin
                  r_lines <= w_lines_inc;
                  if (w_lines_inc == LP_LINES) begin
                    r_state      <= S_TRIG;
                    r_tcnt       <= '0;
                    out_run      <= 1'b1;
                    starttrigger <= 1'b1;
                  end
                end
              end
              S_TRIG: begin
                if (r_tcnt == LP_TRIG) begin
                  r_state      <= S_IDLE;
                  out_run      <= 1'b0;
                  starttrigger <= 1'b0;
                  trig_error   <= 1'b1;
                  relock_count <= w_relock_inc;
                end else begin
                  r_tcnt <= r_tcnt + 16'd1;
                  if (restart) begin
                    r_state      <= S_RUN;
                    r_wd         <= '0;
                    starttrigger <= 1'b0;
                    locked       <= 1'b1;
                  end
                end
              end
              S_RUN: begin
                if (frame_start) begin
                  r_wd <= '0;
                end else if (r_wd == LP_WD) begin
                  r_state      <= S_IDLE;
                  out_run      <= 1'b0;
                  locked       <= 1'b0;
                  relock_count <= w_relock_inc;
                end else begin
                  r_wd <= r_wd + 24'd1;
                end
              end
              default: r_state <= S_IDLE;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_video_start_sequencer.sv
// Directed scenarios plus randomized run against a behavioural model
// of the start sequencer.
`timescale 1ns/1ps
module tb_video_start_sequencer;

  localparam int P_LINES = 2;
  localparam int P_HOLD  = 4;
  localparam int P_TTO   = 16;
  localparam int P_FTO   = 64;

  logic       clock = 0;
  logic       reset = 1;
  logic       line_doubler_req = 0;
  logic       add_line_req = 0;
  logic       frame_start = 0;
  logic       line_done = 0;
  logic       restart = 0;
  logic       out_run, starttrigger, line_doubler;
  logic       add_line, locked, trig_error;
  logic [7:0] relock_count;

  int n_pass = 0;
  int n_total = 0;

  video_start_sequencer #(
    .START_LINES(P_LINES),
    .HOLD_CYCLES(P_HOLD),
    .TRIGGER_TIMEOUT(P_TTO),
    .FRAME_TIMEOUT(P_FTO)
  ) dut (
    .clock(clock),
    .reset(reset),
    .line_doubler_req(line_doubler_req),
    .add_line_req(add_line_req),
    .frame_start(frame_start),
    .line_done(line_done),
    .restart(restart),
    .out_run(out_run),
    .starttrigger(starttrigger),
    .line_doubler(line_doubler),
    .add_line(add_line),
    .locked(locked),
    .trig_error(trig_error),
    .relock_count(relock_count)
  );

  always #5 clock = ~clock;

  wire [13:0] obs = {out_run, starttrigger, line_doubler, add_line,
                     locked, trig_error, relock_count};

  function automatic logic [13:0] mk(
    input logic r, st, ld, al, lk, er, input int cnt);
    return {r, st, ld, al, lk, er, 8'(cnt)};
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic drive(input logic fs, ld, rs);
    frame_start = fs;
    line_done = ld;
    restart = rs;
    @(negedge clock);
    frame_start = 0;
    line_done = 0;
    restart = 0;
  endtask

  task automatic do_reset();
    line_doubler_req = 0;
    add_line_req = 0;
    reset = 1;
    cyc(2);
    reset = 0;
  endtask

  task automatic to_trigger();
    do_reset();
    cyc(1);
    drive(1, 0, 0);
    drive(0, 1, 0);
    drive(0, 1, 0);
  endtask

  task automatic to_run();
    to_trigger();
    drive(0, 0, 1);
  endtask

  task automatic test_reset();
    logic [13:0] e;
    reset = 1;
    cyc(3);
    e = mk(0, 0, 0, 0, 0, 0, 0);
    n_total++;
    if (obs !== e) $display("FAIL reset obs=%h exp=%h", obs, e);
    else n_pass++;
  endtask

  task automatic test_startup();
    logic [13:0] e;
    to_trigger();
    e = mk(1, 1, 0, 0, 0, 0, 0);
    n_total++;
    if (obs !== e) $display("FAIL startup_trig obs=%h exp=%h", obs, e);
    else n_pass++;
    cyc(2);
    n_total++;
    if (obs !== e) $display("FAIL startup_hold obs=%h exp=%h", obs, e);
    else n_pass++;
    drive(0, 0, 1);
    e = mk(1, 0, 0, 0, 1, 0, 0);
    n_total++;
    if (obs !== e) $display("FAIL startup_lock obs=%h exp=%h", obs, e);
    else n_pass++;
  endtask

  task automatic test_fill_restart();
    logic [13:0] e;
    do_reset();
    cyc(1);
    drive(1, 0, 0);
    drive(0, 1, 0);
    drive(1, 0, 0);
    drive(0, 1, 0);
    e = mk(0, 0, 0, 0, 0, 0, 0);
    n_total++;
    if (obs !== e) $display("FAIL fill_restart obs=%h exp=%h", obs, e);
    else n_pass++;
    drive(1, 1, 0);
    drive(0, 1, 0);
    n_total++;
    if (obs !== e) $display("FAIL fill_coincide obs=%h exp=%h", obs, e);
    else n_pass++;
    drive(0, 1, 0);
    e = mk(1, 1, 0, 0, 0, 0, 0);
    n_total++;
    if (obs !== e) $display("FAIL fill_trig obs=%h exp=%h", obs, e);
    else n_pass++;
  endtask

  task automatic test_trig_timeout();
    logic [13:0] e;
    to_trigger();
    cyc(P_TTO - 1);
    e = mk(1, 1, 0, 0, 0, 0, 0);
    n_total++;
    if (obs !== e) $display("FAIL tto_before obs=%h exp=%h", obs, e);
    else n_pass++;
    cyc(1);
    e = mk(0, 0, 0, 0, 0, 1, 1);
    n_total++;
    if (obs !== e) $display("FAIL tto_fire obs=%h exp=%h", obs, e);
    else n_pass++;
    cyc(1);
    drive(1, 0, 0);
    drive(0, 1, 0);
    drive(0, 1, 0);
    drive(0, 0, 1);
    e = mk(1, 0, 0, 0, 1, 1, 1);
    n_total++;
    if (obs !== e) $display("FAIL tto_retrig obs=%h exp=%h", obs, e);
    else n_pass++;
  endtask

  task automatic test_mode_change();
    logic [13:0] e;
    to_run();
    add_line_req = 1;
    cyc(1);
    e = mk(0, 0, 0, 0, 0, 0, 1);
    n_total++;
    if (obs !== e) $display("FAIL mode_stop obs=%h exp=%h", obs, e);
    else n_pass++;
    cyc(P_HOLD - 1);
    n_total++;
    if (obs !== e) $display("FAIL mode_hold obs=%h exp=%h", obs, e);
    else n_pass++;
    cyc(1);
    e = mk(0, 0, 0, 1, 0, 0, 1);
    n_total++;
    if (obs !== e) $display("FAIL mode_apply obs=%h exp=%h", obs, e);
    else n_pass++;
    drive(1, 0, 0);
    drive(0, 1, 0);
    drive(0, 1, 0);
    drive(0, 0, 1);
    e = mk(1, 0, 0, 1, 1, 0, 1);
    n_total++;
    if (obs !== e) $display("FAIL mode_relock obs=%h exp=%h", obs, e);
    else n_pass++;
  endtask

  task automatic test_watchdog();
    logic [13:0] e;
    to_run();
    cyc(40);
    drive(1, 0, 0);
    cyc(P_FTO - 1);
    e = mk(1, 0, 0, 0, 1, 0, 0);
    n_total++;
    if (obs !== e) $display("FAIL wd_before obs=%h exp=%h", obs, e);
    else n_pass++;
    cyc(1);
    e = mk(0, 0, 0, 0, 0, 0, 1);
    n_total++;
    if (obs !== e) $display("FAIL wd_fire obs=%h exp=%h", obs, e);
    else n_pass++;
  endtask

  task automatic test_simultaneous();
    logic [13:0] e;
    to_trigger();
    add_line_req = 1;
    drive(0, 0, 1);
    e = mk(0, 0, 0, 0, 0, 0, 1);
    n_total++;
    if (obs !== e) $display("FAIL sim_chg_restart obs=%h exp=%h", obs, e);
    else n_pass++;
    to_trigger();
    cyc(P_TTO);
    cyc(1);
    drive(1, 0, 0);
    drive(0, 1, 0);
    drive(0, 1, 0);
    e = mk(1, 1, 0, 0, 0, 1, 1);
    n_total++;
    if (obs !== e) $display("FAIL sim_pre_reset obs=%h exp=%h", obs, e);
    else n_pass++;
    reset = 1;
    cyc(1);
    e = mk(0, 0, 0, 0, 0, 0, 0);
    n_total++;
    if (obs !== e) $display("FAIL sim_reset_trig obs=%h exp=%h", obs, e);
    else n_pass++;
    reset = 0;
  endtask

  task automatic test_saturation();
    logic [13:0] e;
    do_reset();
    cyc(1);
    for (int i = 0; i < 260; i++) begin
      line_doubler_req = ~line_doubler_req;
      cyc(7);
    end
    e = mk(0, 0, line_doubler_req, 0, 0, 0, 255);
    n_total++;
    if (obs !== e) $display("FAIL saturate obs=%h exp=%h", obs, e);
    else n_pass++;
  endtask

  // Behavioural model: phases plus elapsed-event counters
  int m_ph;
  int m_lines, m_tcyc, m_quiet, m_held, m_cnt;
  logic m_run, m_trig, m_ld, m_al, m_lock, m_err;

  task automatic m_bump();
    if (m_cnt < 255) m_cnt++;
  endtask

  task automatic m_stop_for_apply();
    m_ph = 5;
    m_held = 0;
    m_run = 0;
    m_trig = 0;
    m_lock = 0;
    m_bump();
  endtask

  task automatic m_step(input logic rst, fs, ld, rs, lq, aq);
    if (rst) begin
      m_ph = 0;
      m_cnt = 0;
      {m_run, m_trig, m_ld, m_al, m_lock, m_err} = '0;
    end else if (m_ph == 0) begin
      m_ld = lq;
      m_al = aq;
      m_ph = 1;
    end else if (m_ph == 5) begin
      m_held++;
      if (m_held == P_HOLD) begin
        m_ld = lq;
        m_al = aq;
        m_ph = 1;
      end
    end else if ({lq, aq} != {m_ld, m_al}) begin
      m_stop_for_apply();
    end else if (m_ph == 1) begin
      if (fs) begin
        m_lines = 0;
        m_ph = 2;
      end
    end else if (m_ph == 2) begin
      if (fs) m_lines = 0;
      else if (ld) begin
        m_lines++;
        if (m_lines == P_LINES) begin
          m_ph = 3;
          m_tcyc = 0;
          m_run = 1;
          m_trig = 1;
        end
      end
    end else if (m_ph == 3) begin
      m_tcyc++;
      if (m_tcyc == P_TTO) begin
        m_ph = 0;
        m_run = 0;
        m_trig = 0;
        m_err = 1;
        m_bump();
      end else if (rs) begin
        m_ph = 4;
        m_quiet = 0;
        m_trig = 0;
        m_lock = 1;
      end
    end else begin
      if (fs) m_quiet = 0;
      else begin
        m_quiet++;
        if (m_quiet == P_FTO) begin
          m_ph = 0;
          m_run = 0;
          m_lock = 0;
          m_bump();
        end
      end
    end
  endtask

  task automatic test_random();
    logic [13:0] e;
    int shown = 0;
    do_reset();
    m_step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4000; i++) begin
      reset = ($urandom_range(0, 599) == 0);
      if ($urandom_range(0, 199) == 0)
        line_doubler_req = ~line_doubler_req;
      if ($urandom_range(0, 199) == 0)
        add_line_req = ~add_line_req;
      frame_start = ($urandom_range(0, 39) == 0);
      line_done = ($urandom_range(0, 3) == 0);
      restart = ($urandom_range(0, 7) == 0);
      m_step(reset, frame_start, line_done, restart,
             line_doubler_req, add_line_req);
      @(negedge clock);
      e = {m_run, m_trig, m_ld, m_al, m_lock, m_err, 8'(m_cnt)};
      n_total++;
      if (obs !== e) begin
        if (shown < 10)
          $display("FAIL random cyc=%0d obs=%h exp=%h", i, obs, e);
        shown++;
      end else n_pass++;
    end
    reset = 0;
    frame_start = 0;
    line_done = 0;
    restart = 0;
  endtask

  initial begin
    test_reset();
    test_startup();
    test_fill_restart();
    test_trig_timeout();
    test_mode_change();
    test_watchdog();
    test_simultaneous();
    test_saturation();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
